// File: rtl/des128_round_ctrl.sv
// des128_round_ctrl: iterative Feistel round sequencer for the 128-bit expanded DES core.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     in_valid/in_ready        upstream handshake; data_in = {L0, R0} after IP
//     decrypt                  mode, latched at accept (1 = reverse subkey order)
//     f_start/f_r_out/f_round  request to the external round function F
//     f_result                 F output, sampled on the last cycle of each round
//     out_valid/out_ready      downstream handshake; data_out = {R16, L16} before FP
//     busy                     high whenever a block is held
module des128_round_ctrl #(
  parameter int F_LAT  = 0,
  parameter int ROUNDS = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         decrypt,
  input  logic [127:0] data_in,
  output logic         f_start,
  output logic [63:0]  f_r_out,
  output logic [3:0]   f_round,
  input  logic [63:0]  f_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  localparam int WW = F_LAT > 0 ? $clog2(F_LAT + 1) : 1;
  state_t         state_q, state_d;
  logic [63:0]    l_q, l_d, r_q, r_d;
  logic [4:0]     rnd_q, rnd_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic           mode_q, mode_d;
  logic [127:0]   dout_q, dout_d;
  logic           last_cyc;
  // The Feistel update happens only once F has had F_LAT cycles to settle.
  assign last_cyc  = state_q == ROUND && wait_q == WW'(F_LAT);
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign f_start   = state_q == ROUND && wait_q == '0;
  assign f_r_out   = r_q;
  assign f_round   = state_q != ROUND ? 4'd0 : mode_q ? 4'(ROUNDS - 1 - int'(rnd_q)) : rnd_q[3:0];
  assign data_out  = dout_q;
  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    rnd_d   = rnd_q;
    wait_d  = wait_q;
    mode_d  = mode_q;
    dout_d  = dout_q;
    if (state_q == IDLE && in_valid) begin
      l_d     = data_in[127:64];
      r_d     = data_in[63:0];
      mode_d  = decrypt;
      rnd_d   = '0;
      wait_d  = '0;
      state_d = ROUND;
    end
    if (last_cyc) begin
      l_d    = r_q;
      r_d    = l_q ^ f_result;
      wait_d = '0;
      rnd_d  = rnd_q + 5'd1;
      // No swap after the final round: output is {R16, L16}.
      if (rnd_q == 5'(ROUNDS - 1)) begin
        state_d = DONE;
        dout_d  = {l_q ^ f_result, r_q};
      end
    end else if (state_q == ROUND) begin
      wait_d = wait_q + 1'b1;
    end
    if (state_q == DONE && out_ready) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      l_q     <= '0;
      r_q     <= '0;
      rnd_q   <= '0;
      wait_q  <= '0;
      mode_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      rnd_q   <= rnd_d;
      wait_q  <= wait_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
    end
  end
endmodule

// File: tb/tb_des128_round_ctrl.sv
// tb_des128_round_ctrl: directed self-checking bench for des128_round_ctrl.
module tb_des128_round_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic in_valid = 1'b0, decrypt = 1'b0, out_ready = 1'b0, stub_id = 1'b0;
  logic [127:0] data_in = '0;
  logic in_ready, f_start, out_valid, busy;
  logic [63:0] f_r_out, f_result;
  logic [3:0] f_round;
  logic [127:0] data_out;
  logic in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic in_ready2, f_start2, out_valid2, busy2;
  logic [63:0] f_r_out2, f_result2;
  logic [3:0] f_round2;
  logic [127:0] data_out2;
  assign f_result  = stub_id ? f_r_out : 64'h0;
  assign f_result2 = f_r_out2;
  des128_round_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .decrypt(decrypt),
    .data_in(data_in), .f_start(f_start), .f_r_out(f_r_out), .f_round(f_round),
    .f_result(f_result), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .busy(busy)
  );
  des128_round_ctrl #(.F_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .decrypt(decrypt),
    .data_in(data_in), .f_start(f_start2), .f_r_out(f_r_out2), .f_round(f_round2),
    .f_result(f_result2), .out_valid(out_valid2), .out_ready(out_ready2),
    .data_out(data_out2), .busy(busy2)
  );
  localparam logic [127:0] D0    = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210};
  localparam logic [127:0] EXP_Z = {64'hFEDCBA9876543210, 64'h0123456789ABCDEF};
  localparam logic [127:0] EXP_I = {64'hFFFFFFFFFFFFFFFF, 64'hFEDCBA9876543210};
  int total = 0, bad = 0;
  int lat, nst;
  int seq [16];
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic consume;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask
  // Accepts one block on dut and runs until out_valid; lat counts cycles from the handshake.
  task automatic run0(input logic [127:0] d, input logic dec, input bit flip);
    data_in = d;
    decrypt = dec;
    in_valid = 1'b1;
    nst = 0;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (f_start) begin
        if (nst < 16) seq[nst] = int'(f_round);
        nst++;
      end
      if (flip && lat == 3) decrypt = ~dec;
      step();
      lat++;
    end
    decrypt = dec;
    if (!out_valid) begin
      total++; bad++;
      $display("FAIL run_timeout out_valid=%b required 1", out_valid);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++;
    if ({in_ready, out_valid, f_start, busy, f_round} !== 8'b1000_0000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b required=10000000", {in_ready, out_valid, f_start, busy, f_round});
    end
    total++;
    if (data_out !== 128'h0 || f_r_out !== 64'h0) begin
      bad++;
      $display("FAIL reset_data data_out=%h f_r_out=%h required 0", data_out, f_r_out);
    end
  endtask
  task automatic test_zero_f;
    stub_id = 1'b0;
    run0(D0, 1'b0, 1'b0);
    total++;
    if (lat != 17) begin bad++; $display("FAIL zero_latency got=%0d required=17", lat); end
    total++;
    if (data_out !== EXP_Z) begin bad++; $display("FAIL zero_data got=%h required=%h", data_out, EXP_Z); end
    consume();
  endtask
  task automatic test_identity;
    stub_id = 1'b1;
    run0(D0, 1'b0, 1'b0);
    total++;
    if (lat != 17) begin bad++; $display("FAIL ident_latency got=%0d required=17", lat); end
    total++;
    if (nst != 16) begin bad++; $display("FAIL ident_starts got=%0d required=16", nst); end
    total++;
    if (data_out !== EXP_I) begin bad++; $display("FAIL ident_data got=%h required=%h", data_out, EXP_I); end
    consume();
    total++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      bad++;
      $display("FAIL ident_release got=%b required=100", {in_ready, out_valid, busy});
    end
  endtask
  task automatic test_round_order;
    stub_id = 1'b0;
    for (int m = 0; m < 4; m++) begin
      run0(D0, m[0], m[1]);
      for (int i = 0; i < 16; i++) begin
        total++;
        if (seq[i] != (m[0] ? 15 - i : i)) begin
          bad++;
          $display("FAIL round_order mode=%0d idx=%0d got=%0d required=%0d", m, i, seq[i], m[0] ? 15 - i : i);
        end
      end
      consume();
    end
  endtask
  task automatic test_flat2;
    logic [63:0] r0;
    logic [3:0] k0;
    decrypt = 1'b0;
    data_in = D0;
    in_valid2 = 1'b1;
    step();
    in_valid2 = 1'b0;
    r0 = '0;
    k0 = '0;
    for (int c = 1; c <= 48; c++) begin
      total++;
      if (f_start2 !== ((c - 1) % 3 == 0) || out_valid2 !== 1'b0) begin
        bad++;
        $display("FAIL lat2_start cycle=%0d f_start=%b out_valid=%b", c, f_start2, out_valid2);
      end
      if ((c - 1) % 3 == 0) begin
        r0 = f_r_out2;
        k0 = f_round2;
      end
      total++;
      if (f_r_out2 !== r0 || f_round2 !== k0 || f_round2 !== 4'((c - 1) / 3)) begin
        bad++;
        $display("FAIL lat2_stable cycle=%0d f_round=%0d required=%0d", c, f_round2, (c - 1) / 3);
      end
      step();
    end
    total++;
    if (out_valid2 !== 1'b1) begin bad++; $display("FAIL lat2_done out_valid=%b required 1 at cycle 49", out_valid2); end
    total++;
    if (data_out2 !== EXP_I) begin bad++; $display("FAIL lat2_data got=%h required=%h", data_out2, EXP_I); end
    out_ready2 = 1'b1;
    step();
    out_ready2 = 1'b0;
  endtask
  task automatic test_back_to_back;
    int c;
    stub_id = 1'b1;
    out_ready = 1'b0;
    run0(D0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || data_out !== EXP_I) begin
        bad++;
        $display("FAIL backpressure cycle=%0d out_valid=%b in_ready=%b data=%h", i, out_valid, in_ready, data_out);
      end
    end
    stub_id = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    data_in = D0;
    step();
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    step();
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accept busy=%b in_ready=%b required 1/0", busy, in_ready);
    end
    c = 1;
    while (!out_valid && c < 200) begin
      step();
      c++;
    end
    total++;
    if (c != 17 || data_out !== EXP_Z) begin
      bad++;
      $display("FAIL b2b_second latency=%0d data=%h required 17 %h", c, data_out, EXP_Z);
    end
    consume();
  endtask
  task automatic test_reset_mid;
    stub_id = 1'b1;
    data_in = D0;
    decrypt = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    total++;
    if (f_round !== 4'd7) begin bad++; $display("FAIL mid_round got=%0d required=7", f_round); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({in_ready, out_valid, busy, f_start, f_round} !== 8'b1000_0000 || data_out !== 128'h0) begin
      bad++;
      $display("FAIL mid_reset ctrl=%b data=%h required 10000000 0", {in_ready, out_valid, busy, f_start, f_round}, data_out);
    end
    run0(D0, 1'b0, 1'b0);
    total++;
    if (lat != 17 || data_out !== EXP_I) begin
      bad++;
      $display("FAIL mid_recover latency=%0d data=%h required 17 %h", lat, data_out, EXP_I);
    end
    consume();
  endtask
  initial begin
    test_reset();
    test_zero_f();
    test_identity();
    test_round_order();
    test_flat2();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
